// File: rtl/qsn_pkg.sv
// Shared constants and types for the QSN forward/inverse datapath.
//   LIFTING_FACTOR : block width in bits
//   SHIFT_WIDTH    : width of a rotation amount
//   block_t        : one lifting-factor block
//   shift_t        : one rotation amount
package qsn_pkg;
  localparam int LIFTING_FACTOR = 4;
  localparam int SHIFT_WIDTH    = $clog2(LIFTING_FACTOR);

  typedef logic [LIFTING_FACTOR-1:0] block_t;
  typedef logic [SHIFT_WIDTH-1:0]    shift_t;
endpackage

// File: rtl/qsn_shift_fifo.sv
// Shift-value FIFO: holds rotation amounts recorded by the forward QSN until
// the matching block returns.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write din at tail (ignored when full)
//   pop, dout  : dout is the head entry; pop advances head (ignored when empty)
//   full/empty : status derived from the registered count
//   count      : number of stored entries, 0..DEPTH
module qsn_shift_fifo #(
  parameter  int W     = qsn_pkg::SHIFT_WIDTH,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  import qsn_pkg::*;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/qsn_deshift.sv
// Inverse quasi-cyclic shift: undoes the forward rotation O[i] = I[(i+s) mod LF]
// by producing data_out[j] = data_in[(j-s) mod LF], with s popped from a FIFO
// of shifts recorded on the forward side.
//   shift_in/_valid/_ready : shift values from the forward QSN
//   data_in/_valid/_ready  : returning rotated blocks (need a stored shift)
//   data_out/_valid/_ready : de-rotated blocks, one register stage
//   fifo_count             : number of stored shifts
//   err_shift              : sticky, a shift >= LIFTING_FACTOR was pushed
module qsn_deshift #(
  parameter int LIFTING_FACTOR = qsn_pkg::LIFTING_FACTOR,
  parameter int SHIFT_WIDTH    = $clog2(LIFTING_FACTOR),
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SHIFT_WIDTH-1:0]        shift_in,
  input  logic                          shift_in_valid,
  output logic                          shift_in_ready,
  input  logic [LIFTING_FACTOR-1:0]     data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic [LIFTING_FACTOR-1:0]     data_out,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_shift
);
  import qsn_pkg::*;

  localparam logic [SHIFT_WIDTH:0] LF_W = (SHIFT_WIDTH+1)'(LIFTING_FACTOR);

  logic                      full, empty;
  logic                      push, accept, bad_shift;
  logic [SHIFT_WIDTH-1:0]    push_val, head;
  logic [LIFTING_FACTOR-1:0] rot;

  // Out-of-range shifts are stored as 0 so the datapath never indexes past LF.
  assign bad_shift      = ({1'b0, shift_in} >= LF_W);
  assign push_val       = bad_shift ? '0 : shift_in;
  assign shift_in_ready = !full;
  assign push           = shift_in_valid && shift_in_ready;
  // Uses registered count only, so a same-cycle push cannot feed this pop.
  assign data_in_ready  = !empty && (!data_out_valid || data_out_ready);
  assign accept         = data_in_valid && data_in_ready;

  qsn_shift_fifo #(.W(SHIFT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_val),
    .pop   (accept),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // (j - s) mod LF computed as j + LF - s with one conditional subtract;
  // s < LF so the sum lies in [1, 2*LF-1].
  for (genvar j = 0; j < LIFTING_FACTOR; j++) begin : g_rot
    logic [SHIFT_WIDTH:0]   sum;
    logic [SHIFT_WIDTH-1:0] idx;
    assign sum    = (SHIFT_WIDTH+1)'(j + LIFTING_FACTOR) - {1'b0, head};
    assign idx    = SHIFT_WIDTH'((sum >= LF_W) ? (sum - LF_W) : sum);
    assign rot[j] = data_in[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      err_shift      <= 1'b0;
    end else begin
      if (push && bad_shift) err_shift <= 1'b1;
      if (accept) begin
        data_out       <= rot;
        data_out_valid <= 1'b1;
      end else if (data_out_ready) begin
        data_out_valid <= 1'b0;   // data_out keeps its last value
      end
    end
  end
endmodule

// File: tb/tb_qsn_deshift.sv
module tb_qsn_deshift;
  localparam int LF = 4;
  localparam int D  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] shift_in;
  logic       shift_in_valid, shift_in_ready;
  logic [3:0] data_in;
  logic       data_in_valid, data_in_ready;
  logic [3:0] data_out;
  logic       data_out_valid, data_out_ready;
  logic [2:0] fifo_count;
  logic       err_shift;

  int tests = 0;
  int fails = 0;

  // Reference state: stored shifts, expected outputs, model output-valid.
  int         sh_q[$];
  logic [3:0] exp_q[$];
  bit         mov;

  qsn_deshift dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .shift_in       (shift_in),
    .shift_in_valid (shift_in_valid),
    .shift_in_ready (shift_in_ready),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .fifo_count     (fifo_count),
    .err_shift      (err_shift)
  );

  always #5 clk = ~clk;

  // Undoing O[i]=I[(i+s)] means rotating left by s.
  function automatic logic [3:0] rotl(logic [3:0] d, int s);
    logic [7:0] w;
    w = {d, d} << s;
    return w[7:4];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; entered and left at posedge+2.
  task automatic cycle(bit siv, logic [1:0] sh, bit div, logic [3:0] din, bit dor);
    bit push, acc;
    shift_in_valid = siv;
    shift_in       = sh;
    data_in_valid  = div;
    data_in        = din;
    data_out_ready = dor;
    #1;
    chk("shift_in_ready", shift_in_ready, sh_q.size() != D);
    chk("data_in_ready", data_in_ready, sh_q.size() != 0 && (!mov || dor));
    chk("fifo_count", fifo_count, sh_q.size());
    chk("data_out_valid", data_out_valid, mov);
    chk("err_shift", err_shift, 0);
    push = siv && sh_q.size() != D;
    acc  = div && sh_q.size() != 0 && (!mov || dor);
    if (acc) begin
      exp_q.push_back(rotl(din, sh_q.pop_front()));
      mov = 1'b1;
    end else if (dor) begin
      mov = 1'b0;
    end
    if (push) sh_q.push_back(int'(sh));
    @(posedge clk); #2;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 1);
  endtask

  // Monitor: compares each output handshake against the scoreboard queue
  // and checks that a stalled output stays put.
  logic [3:0] held;
  bit         held_v = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        held_v = 0;
      end else begin
        if (held_v) begin
          chk("hold_data", data_out, held);
          chk("hold_valid", data_out_valid, 1);
        end
        held_v = 0;
        if (data_out_valid && data_out_ready) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL data_out: got unexpected block %0h expected none", data_out);
          end else begin
            chk("data_out", data_out, exp_q.pop_front());
          end
        end else if (data_out_valid) begin
          held   = data_out;
          held_v = 1;
        end
      end
    end
  end

  logic [3:0] seq4 [4];

  initial begin
    rst_n = 0; shift_in_valid = 0; shift_in = 0;
    data_in_valid = 0; data_in = 0; data_out_ready = 1; mov = 0;
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_dvalid", data_out_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_sready", shift_in_ready, 1);
    chk("rst_dready", data_in_ready, 0);
    chk("rst_err", err_shift, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #2;

    // Basic de-rotations
    cycle(1, 2'd1, 0, 0, 1);
    cycle(0, 0, 1, 4'b0001, 1);
    chk("t1_out", data_out, 4'b0010);
    chk("t1_count", fifo_count, 0);
    cycle(1, 2'd3, 0, 0, 1);
    cycle(0, 0, 1, 4'b1000, 1);
    chk("t2_out", data_out, 4'b0100);
    cycle(1, 2'd0, 0, 0, 1);
    cycle(0, 0, 1, 4'b1011, 1);
    chk("t2b_out", data_out, 4'b1011);
    idle(1);

    // Fill, overfill, then drain in order
    cycle(1, 2'd1, 0, 0, 1);
    cycle(1, 2'd2, 0, 0, 1);
    cycle(1, 2'd3, 0, 0, 1);
    cycle(1, 2'd0, 0, 0, 1);
    chk("full_count", fifo_count, 4);
    chk("full_ready", shift_in_ready, 0);
    cycle(1, 2'd2, 0, 0, 1);
    chk("ovf_count", fifo_count, 4);
    seq4 = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 4'b0001, 1);
      chk("order_out", data_out, seq4[i]);
    end
    idle(1);

    // No bypass: shift and data in the same cycle on an empty FIFO
    cycle(1, 2'd2, 1, 4'b0001, 1);
    cycle(0, 0, 1, 4'b0001, 1);
    chk("nobypass_out", data_out, 4'b0100);
    idle(1);

    // Backpressure for 3 cycles, then back-to-back resume
    cycle(1, 2'd1, 0, 0, 1);
    cycle(1, 2'd2, 0, 0, 1);
    cycle(1, 2'd3, 0, 0, 1);
    cycle(0, 0, 1, 4'b0001, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 4'b0001, 0);
    chk("bp_out", data_out, 4'b0010);
    cycle(0, 0, 1, 4'b0001, 1);
    chk("bp_next", data_out, 4'b0100);
    cycle(0, 0, 1, 4'b0001, 1);
    chk("bp_next2", data_out, 4'b1000);
    idle(2);

    // Reset mid-operation with count=2 and a pending output
    cycle(1, 2'd1, 0, 0, 1);
    cycle(1, 2'd2, 0, 0, 1);
    cycle(1, 2'd3, 0, 0, 1);
    cycle(0, 0, 1, 4'b0101, 0);
    chk("pre_rst_count", fifo_count, 2);
    chk("pre_rst_valid", data_out_valid, 1);
    shift_in_valid = 0; data_in_valid = 0; data_out_ready = 1;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", data_out_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_sready", shift_in_ready, 1);
    chk("mid_rst_err", err_shift, 0);
    sh_q.delete(); exp_q.delete(); mov = 0;
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #2;

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom % 2, 2'($urandom), $urandom_range(0, 2) != 0,
            4'($urandom), $urandom_range(0, 3) != 0);

    idle(8);
    chk("drain_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/qsn_deshift.md
Name: qsn_deshift

Overview:
- Inverse quasi-cyclic shift stage for the LDPC datapath.
- The forward QSN rotates each lifting-factor block as O[i] = I[(i+s) mod LF]. This block undoes that rotation: data_out[j] = data_in[(j-s) mod LF].
- The forward side records each shift value s in an internal shift FIFO. When the processed block comes back, the block pops the matching s and applies the inverse rotation.
- It sits on the return path between the check-node units and the variable-node memory.

Parameters:
- LIFTING_FACTOR, 4, block width in bits (LF); must be ≥2.
- SHIFT_WIDTH, 2, width of shift values; equals clog2(LIFTING_FACTOR).
- FIFO_DEPTH, 4, number of outstanding shift values held; power of two, ≥2.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- shift_in  input  SHIFT_WIDTH  shift value used by the forward QSN.
- shift_in_valid  input  1  shift_in is valid.
- shift_in_ready  output  1  shift FIFO can accept a value.
- data_in  input  LIFTING_FACTOR  returning rotated block.
- data_in_valid  input  1  data_in is valid.
- data_in_ready  output  1  block can accept data_in.
- data_out  output  LIFTING_FACTOR  de-rotated block.
- data_out_valid  output  1  data_out holds a valid block.
- data_out_ready  input  1  downstream accepts data_out.
- fifo_count  output  clog2(FIFO_DEPTH)+1  number of shift entries stored.
- err_shift  output  1  sticky flag: a shift value ≥ LIFTING_FACTOR was pushed.

Behaviour:
- Reset (asynchronous on rst_n low, released synchronously to clk):
  - shift FIFO empty; fifo_count=0;
  - data_out=0, data_out_valid=0, err_shift=0;
  - shift_in_ready=1, data_in_ready=0.
  - Reset mid-operation discards all stored shifts and any pending output block.
- Shift push:
  - shift_in_ready = (fifo_count != FIFO_DEPTH). It is purely a function of registered count; there is no pop-through when full.
  - A transfer occurs when shift_in_valid && shift_in_ready. The value is written at the tail and fifo_count increments next cycle.
  - If shift_in ≥ LIFTING_FACTOR, the entry is stored as 0 and err_shift sets (cleared only by reset). With defaults this cannot happen; it matters for non-power-of-two LF.
- Data accept:
  - data_in_ready = (fifo_count != 0) && (!data_out_valid || data_out_ready).
  - The FIFO must hold an entry at the start of the cycle. A shift pushed in the same cycle is not usable (no bypass).
  - On data_in_valid && data_in_ready:
    - pop head entry s;
    - next cycle data_out[j] = data_in[(j - s) mod LF] for all j;
    - data_out_valid=1.
  - Latency is exactly 1 cycle from accept to data_out_valid.
- Output register:
  - Single stage. Holds data_out and data_out_valid stable while data_out_valid && !data_out_ready.
  - Clears data_out_valid on handshake unless a new block is accepted in the same cycle.
  - data_out is not cleared when it becomes invalid.
- Simultaneous push and pop in one cycle: fifo_count is unchanged, and head/tail pointers both advance.
- Ordering: shifts are consumed strictly FIFO. The N-th accepted data block uses the N-th pushed shift.
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH. fifo_count saturates by construction and never exceeds FIFO_DEPTH.
- Protocol rules:
  - valid signals must not depend on ready; this block's ready outputs do not depend on its own valid inputs.
  - Inputs may drop valid without transfer.

Decomposition:
- Package qsn_pkg:
  - LIFTING_FACTOR and SHIFT_WIDTH constants shared with the forward QSN;
  - typedefs block_t (LIFTING_FACTOR bits) and shift_t (SHIFT_WIDTH bits).
- Sub-module qsn_shift_fifo:
  - synchronous FIFO of shift_t with push/pop, full/empty and count outputs, async active-low reset.
- The inverse rotation is a combinational loop in the top module.

Test Plan:
- Push shift 1, then data_in 4'b0001 → next cycle data_out=4'b0010, data_out_valid=1, fifo_count=0.
- Push shift 3, then data_in 4'b1000 → data_out=4'b0100. Push shift 0, then data_in 4'b1011 → data_out=4'b1011.
- Push shifts 1,2,3,0 with no data → shift_in_ready=0 after the 4th push, fifo_count=4. A 5th push is ignored. Then data 4'b0001 ×4 → outputs 0010, 0100, 1000, 0001 in order.
- FIFO empty, shift_in_valid and data_in_valid asserted in the same cycle → data_in_ready=0 that cycle; data accepted the next cycle; result correct.
- data_out_ready held low 3 cycles after output 4'b0010 → data_out and data_out_valid stable, data_in_ready=0. Release → handshake; back-to-back accept resumes.
- rst_n pulsed low with fifo_count=2 and data_out_valid=1 → immediately data_out_valid=0, fifo_count=0, shift_in_ready=1, err_shift=0.
